// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates the CPU MEM stage and the debug/loader port onto a
// single-port data memory. The CPU has priority; a starvation counter forces a
// debug grant after STARVE_LIMIT consecutive denials. Reads are non-pipelined
// and take READ_LATENCY cycles; the CPU is stalled until its access completes.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 10,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    output logic                   cpu_stall,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   cpu_rvalid,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [ADDR_WIDTH-1:0]  dbg_addr,
    input  logic [DATA_WIDTH-1:0]  dbg_wdata,
    output logic                   dbg_done,
    output logic [DATA_WIDTH-1:0]  dbg_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [INDEX_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam logic [3:0] WAIT_INIT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        IDLE,
        RD_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [3:0]              starve_cnt_q, starve_cnt_d;
    logic                    owner_q, owner_d;     // 1 = debug owns the outstanding read
    logic                    cpu_rvalid_q, cpu_rvalid_d;
    logic                    dbg_done_q, dbg_done_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;

    logic                    dbg_win;
    logic                    cpu_win;
    logic                    cpu_wr_issue;

    // Byte-offset and upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2], cpu_addr[1:0],
                                dbg_addr[ADDR_WIDTH-1:INDEX_WIDTH+2], dbg_addr[1:0]};

    // Arbitration, memory issue, read-wait sequencing and starvation tracking.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        cpu_rvalid_d = 1'b0;
        dbg_done_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dbg_win      = 1'b0;
        cpu_win      = 1'b0;
        cpu_wr_issue = 1'b0;

        case (state_q)
            IDLE: begin
                // No access is launched while reset is held.
                if (reset_n) begin
                    dbg_win = dbg_req && (!cpu_req || (starve_cnt_q == STARVE_MAX));
                    cpu_win = cpu_req && !dbg_win;
                end

                if (dbg_win) begin
                    mem_en       = 1'b1;
                    mem_we       = dbg_we;
                    mem_addr     = dbg_addr[INDEX_WIDTH+1:2];
                    mem_wdata    = dbg_wdata;
                    starve_cnt_d = '0;
                    if (dbg_we) begin
                        dbg_done_d = 1'b1;
                    end else begin
                        state_d    = RD_WAIT;
                        wait_cnt_d = WAIT_INIT;
                        owner_d    = 1'b1;
                    end
                end else if (cpu_win) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr[INDEX_WIDTH+1:2];
                    mem_wdata = cpu_wdata;
                    if (!dbg_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    if (cpu_we) begin
                        cpu_wr_issue = 1'b1;
                    end else begin
                        state_d    = RD_WAIT;
                        wait_cnt_d = WAIT_INIT;
                        owner_d    = 1'b0;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end

            RD_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        dbg_rdata_d = mem_rdata;
                        dbg_done_d  = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_rdata;
                        cpu_rvalid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered read-return outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_done_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_done_q   <= dbg_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign cpu_stall  = cpu_req && !(cpu_wr_issue || cpu_rvalid_q);
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_done   = dbg_done_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory of READ_LATENCY 2.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_done;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_done   (dbg_done),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: write on mem_en&&mem_we, read data two cycles after issue.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_p1 <= mem[mem_addr];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [9:0] word, input logic [31:0] data);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        settle;
        check_vec("wr_mem_en", 32'(mem_en), 32'd1);
        check_vec("wr_mem_we", 32'(mem_we), 32'd1);
        check_vec("wr_mem_addr", 32'(mem_addr), 32'(word));
        check_vec("wr_mem_wdata", mem_wdata, data);
        check_vec("wr_stall", 32'(cpu_stall), 32'd0);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, input logic [9:0] word, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) cpu_req = 1'b0;
            settle;
            check_vec("rd_mem_en", 32'(mem_en), 32'(c == 0));
            if (c == 0) check_vec("rd_mem_addr", 32'(mem_addr), 32'(word));
            check_vec("rd_stall", 32'(cpu_stall), 32'(c < 3));
            check_vec("rd_rvalid", 32'(cpu_rvalid), 32'(c == 3));
            if (c == 3) check_vec("rd_data", cpu_rdata, exp);
            tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic [9:0]  b2b_word [3];
        logic [31:0] b2b_exp  [3];
        b2b_word = '{10'd1, 10'd2, 10'd3};
        b2b_exp  = '{32'd1, 32'd2, 32'd10};

        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        tick; tick;
        settle;
        check_vec("rst_mem_en", 32'(mem_en), 32'd0);
        check_vec("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check_vec("rst_done", 32'(dbg_done), 32'd0);
        check_vec("rst_stall", 32'(cpu_stall), 32'd0);
        check_vec("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_vec("rst_dbg_rdata", dbg_rdata, 32'd0);
        tick;
        reset_n = 1'b1;

        // Debug preload of words 0..15 with value = index.
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'(i * 4); dbg_wdata = 32'(i);
            settle;
            check_vec("pre_mem_en", 32'(mem_en), 32'd1);
            check_vec("pre_mem_addr", 32'(mem_addr), 32'(i));
            check_vec("pre_done_early", 32'(dbg_done), 32'd0);
            tick;
            dbg_req = 1'b0; dbg_we = 1'b0;
            settle;
            check_vec("pre_done", 32'(dbg_done), 32'd1);
            if (dbg_done) ndone++;
            tick;
        end
        check_vec("pre_done_count", 32'(ndone), 32'd16);

        // CPU write then read of word 3.
        cpu_write(32'h0C, 10'd3, 32'd10);
        cpu_read(32'h0C, 10'd3, 32'd10);

        // CPU write 89 to 0x1C; read back through an address with low bits set.
        cpu_write(32'h1C, 10'd7, 32'd89);
        cpu_read(32'h1E, 10'd7, 32'd89);

        // Back-to-back reads of words 1, 2, 3.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'(b2b_word[0]) << 2;
        for (int c = 0; c < 10; c++) begin
            if (c == 3 || c == 6) cpu_addr = 32'(b2b_word[c / 3]) << 2;
            if (c == 9) cpu_req = 1'b0;
            settle;
            check_vec("b2b_mem_en", 32'(mem_en), 32'((c % 3 == 0) && (c < 9)));
            if ((c % 3 == 0) && (c < 9)) check_vec("b2b_mem_addr", 32'(mem_addr), 32'(b2b_word[c / 3]));
            check_vec("b2b_rvalid", 32'(cpu_rvalid), 32'((c % 3 == 0) && (c > 0)));
            if ((c % 3 == 0) && (c > 0)) check_vec("b2b_data", cpu_rdata, b2b_exp[c / 3 - 1]);
            check_vec("b2b_stall", 32'(cpu_stall), 32'((c < 9) && !((c % 3 == 0) && (c > 0))));
            tick;
        end

        // Contention: CPU writes word 20 continuously, debug reads word 5.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd80; cpu_wdata = 32'hA5;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd20;
        for (int c = 0; c < 9; c++) begin
            logic dg, cg;
            dg = (c == 4);
            cg = (c < 4) || (c == 7);
            if (c == 7) dbg_req = 1'b0;
            if (c == 8) cpu_req = 1'b0;
            settle;
            check_vec("con_mem_en", 32'(mem_en), 32'(dg || cg));
            if (dg) begin
                check_vec("con_dbg_addr", 32'(mem_addr), 32'd5);
                check_vec("con_dbg_we", 32'(mem_we), 32'd0);
            end
            if (cg) begin
                check_vec("con_cpu_addr", 32'(mem_addr), 32'd20);
                check_vec("con_cpu_we", 32'(mem_we), 32'd1);
            end
            check_vec("con_stall", 32'(cpu_stall), 32'((c < 8) && !cg));
            check_vec("con_done", 32'(dbg_done), 32'(c == 7));
            if (c == 7) check_vec("con_dbg_rdata", dbg_rdata, 32'd5);
            tick;
        end
        cpu_we = 1'b0;

        // Reset asserted during a CPU read's wait, held for two cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h04;
        settle;
        check_vec("rw_issue", 32'(mem_en), 32'd1);
        tick;
        reset_n = 1'b0;
        settle;
        check_vec("rw_wait_mem_en", 32'(mem_en), 32'd0);
        tick;
        settle;
        check_vec("rw_rst_mem_en", 32'(mem_en), 32'd0);
        check_vec("rw_rst_rvalid", 32'(cpu_rvalid), 32'd0);
        tick;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) cpu_req = 1'b0;
            settle;
            check_vec("rw_mem_en", 32'(mem_en), 32'(c == 0));
            if (c == 0) check_vec("rw_mem_addr", 32'(mem_addr), 32'd1);
            check_vec("rw_rvalid", 32'(cpu_rvalid), 32'(c == 3));
            check_vec("rw_stall", 32'(cpu_stall), 32'(c < 3));
            if (c == 3) check_vec("rw_data", cpu_rdata, 32'd1);
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter for the pipeline's single-port data memory. Master 0 is the CPU MEM stage and master 1 is the debug/loader port used by benches and firmware preload. The CPU has priority with a starvation guard for the debug master. The block sequences non-pipelined memory accesses of configurable read latency and produces the CPU stall that freezes the pipeline while the CPU waits.

Parameters:
ADDR_WIDTH, 32, byte-address width of both master ports
DATA_WIDTH, 32, data word width
INDEX_WIDTH, 10, memory word-index width (mem_addr = addr[INDEX_WIDTH+1:2])
READ_LATENCY, 2, cycles from read issue to mem_rdata valid (1..15)
STARVE_LIMIT, 4, consecutive cycles debug may be denied before forced grant (1..15)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, held until not stalled
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
cpu_wdata  in  DATA_WIDTH  write data
cpu_stall  out  1  CPU request not yet complete; pipeline holds
cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_rvalid
cpu_rvalid  out  1  one-cycle pulse, CPU read data valid
dbg_req  in  1  debug request, held until dbg_done
dbg_we  in  1  1 = write
dbg_addr  in  ADDR_WIDTH  byte address
dbg_wdata  in  DATA_WIDTH  write data
dbg_done  out  1  one-cycle pulse, debug access complete (read data valid)
dbg_rdata  out  DATA_WIDTH  read data, valid with dbg_done
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  INDEX_WIDTH  word index
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data, valid READ_LATENCY cycles after mem_en

Behaviour:
- Reset: reset_n = 0 at a rising edge puts the FSM in IDLE, clears starve_cnt, and drives mem_en, cpu_rvalid, dbg_done and the registered rdata outputs to 0. Any outstanding read is dropped with no rvalid/done. cpu_stall follows its combinational rule.
- FSM states: IDLE, RD_WAIT.
- IDLE arbitration, evaluated each cycle:
  - Debug wins if dbg_req and (not cpu_req, or starve_cnt == STARVE_LIMIT).
  - Otherwise the CPU wins if cpu_req.
  - The winner is issued combinationally in the same cycle: mem_en = 1 and mem_we/addr/wdata muxed from the winner.
- Write issued: completes this cycle and the FSM stays in IDLE.
  - CPU write: cpu_stall = 0 this cycle.
  - Debug write: dbg_done pulses the next cycle.
- Read issued: go to RD_WAIT with wait_cnt = READ_LATENCY-1 and record the owner.
  - In RD_WAIT, mem_en = 0 and wait_cnt decrements each cycle.
  - When wait_cnt == 0, capture mem_rdata into the owner's rdata register and pulse the owner's rvalid/done the next cycle. The FSM returns to IDLE at that same edge.
  - New arbitration occurs in the cycle rvalid/done is high, so back-to-back reads leave no idle gap.
- cpu_stall = cpu_req and not (CPU write issued this cycle, or cpu_rvalid high this cycle). A CPU read therefore stalls READ_LATENCY+1 cycles minimum (issue cycle plus wait), plus arbitration loss.
  - In the cpu_rvalid cycle the CPU may present a new request; it is arbitrated normally.
  - A stalled CPU must hold its request fields stable.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle in which dbg_req = 1 and the CPU is granted.
  - Clears when debug is granted or dbg_req = 0.
  - Holds in RD_WAIT.
- Both requesting when starve_cnt == STARVE_LIMIT: debug wins, the CPU stalls at least one more access.
- Requests that drop before being granted are allowed and have no effect. Requests that drop mid-read are not allowed; the read completes anyway.
- The address low bits are ignored; no misalignment error is raised.

Test Plan:
- Reset: assert reset_n = 0 during a CPU read's RD_WAIT, then release -> no cpu_rvalid, mem_en = 0, state IDLE, next CPU read issues on the first cycle after release.
- CPU read alone: mem word 3 = 10, cpu_req read addr 0x0C -> mem_en in cycle 0, cpu_stall high for 3 cycles, cpu_rvalid in cycle 3 with cpu_rdata = 10.
- CPU write alone: write 89 to addr 0x1C -> mem_en/mem_we with mem_addr = 7 in the same cycle, cpu_stall = 0, then readback returns 89.
- Debug preload: dbg writes words 0..15 with value = index, CPU idle -> 16 dbg_done pulses, memory holds 0..15.
- Contention: cpu_req writes continuously, dbg_req read of word 5 -> CPU granted 4 times, debug granted on the 5th arbitration, CPU stalled during debug's read, dbg_rdata = 5.
- Back-to-back: CPU reads words 1, 2, 3 consecutively -> issues spaced exactly READ_LATENCY+1 = 3 cycles apart, rvalid pulses return correct data in order.
